// File: rtl/eth_tx_scheduler.sv
// eth_tx_scheduler: round-robin two-source RMII TX dibit scheduler with preamble/SFD and IFG.
// Define ETH_TX_SCHED_PAD_EN to zero-pad short frames up to MIN_FRAME bytes.
module eth_tx_scheduler #(
  parameter int IFG_CYCLES = 48,
  parameter int PREAMBLE_BYTES = 7
`ifdef ETH_TX_SCHED_PAD_EN
  , parameter int MIN_FRAME = 60
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s0_valid,
  input  logic [7:0] s0_data,
  input  logic       s0_last,
  output logic       s0_ready,
  input  logic       s1_valid,
  input  logic [7:0] s1_data,
  input  logic       s1_last,
  output logic       s1_ready,
  output logic       axiov,
  output logic [1:0] axiod,
  output logic [1:0] grant,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);
  localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_BYTES * 4 + 3);
  localparam logic [7:0] IFG_LAST = 8'(IFG_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, PRE, DATA, IFG
`ifdef ETH_TX_SCHED_PAD_EN
    , PAD
`endif
  } state_t;
  state_t state, state_n;
  logic [7:0] cnt, byte_q, sd;
  logic sel, pri, last_q, ready, done_n, und_n, sv, sl, req, sel_n;
`ifdef ETH_TX_SCHED_PAD_EN
  logic [6:0] bytes;
`endif
  assign sv = sel ? s1_valid : s0_valid;
  assign sd = sel ? s1_data : s0_data;
  assign sl = sel ? s1_last : s0_last;
  assign req = s0_valid | s1_valid;
  // pri names the source that wins when both request at once
  assign sel_n = (s0_valid & s1_valid) ? pri : s1_valid;
  assign busy = state != IDLE;
  assign axiov = busy && state != IFG;
  assign grant = axiov ? (sel ? 2'b10 : 2'b01) : 2'b00;
  assign axiod = state == PRE ? (cnt == PRE_LAST ? 2'b11 : 2'b01) : axiov ? byte_q[{cnt[1:0], 1'b0} +: 2] : 2'b00;
  assign s0_ready = ready & ~sel;
  assign s1_ready = ready & sel;
  always_comb begin
    state_n = state;
    ready = 1'b0;
    done_n = 1'b0;
    und_n = 1'b0;
    case (state)
      IDLE: state_n = req ? PRE : IDLE;
      PRE:
        if (cnt == PRE_LAST) begin
          ready = 1'b1;
          und_n = ~sv;
          state_n = sv ? DATA : IFG;
        end
      DATA:
        if (cnt[1:0] == 2'd3) begin
          if (last_q) begin
`ifdef ETH_TX_SCHED_PAD_EN
            done_n = bytes >= 7'(MIN_FRAME);
            state_n = done_n ? IFG : PAD;
`else
            done_n = 1'b1;
            state_n = IFG;
`endif
          end else begin
            ready = 1'b1;
            und_n = ~sv;
            state_n = sv ? DATA : IFG;
          end
        end
`ifdef ETH_TX_SCHED_PAD_EN
      PAD:
        if (cnt[1:0] == 2'd3 && bytes >= 7'(MIN_FRAME - 1)) begin
          done_n = 1'b1;
          state_n = IFG;
        end
`endif
      IFG: state_n = cnt == IFG_LAST ? IDLE : IFG;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= 8'd0;
      sel <= 1'b0;
      pri <= 1'b0;
      byte_q <= 8'd0;
      last_q <= 1'b0;
      frame_done <= 1'b0;
      underrun <= 1'b0;
`ifdef ETH_TX_SCHED_PAD_EN
      bytes <= 7'd0;
`endif
    end else begin
      state <= state_n;
      frame_done <= done_n;
      underrun <= und_n;
      cnt <= (state_n == state && state != IDLE) ? cnt + 8'd1 : 8'd0;
      if (state == IDLE && req) begin
        sel <= sel_n;
        pri <= ~sel_n;
      end
      if (ready && sv) begin
        byte_q <= sd;
        last_q <= sl;
      end
`ifdef ETH_TX_SCHED_PAD_EN
      if (state == IDLE) bytes <= 7'd0;
      else if ((ready && sv) || (state == PAD && cnt[1:0] == 2'd3)) bytes <= bytes + {6'd0, bytes != 7'd127};
      if (state_n == PAD && state != PAD) byte_q <= 8'd0;
`endif
    end
endmodule

// File: tb/tb_eth_tx_scheduler.sv
// tb_eth_tx_scheduler: randomized frame sources checked cycle-by-cycle against a frame-level timeline model.
module tb_eth_tx_scheduler;
  localparam int H = 4096;
  logic clk = 1'b0, rst_n = 1'b1;
  logic s0_valid = 1'b0, s0_last = 1'b0, s1_valid = 1'b0, s1_last = 1'b0;
  logic [7:0] s0_data = 8'd0, s1_data = 8'd0;
  logic s0_ready, s1_ready, axiov, busy, frame_done, underrun;
  logic [1:0] axiod, grant;
  int errors = 0, checks = 0;
  logic ev[H], eb[H], efd[H], eu[H], er0[H], er1[H];
  logic [1:0] ed[H], eg[H];
  logic [7:0] fb[2][4][64];
  int fn[2][4], fdrop[2][4], nf[2], fi[2], ptr[2];
  int mpri = 0, horizon = 0;

  always #5 clk = ~clk;

  eth_tx_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .s0_valid(s0_valid), .s0_data(s0_data), .s0_last(s0_last), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_data(s1_data), .s1_last(s1_last), .s1_ready(s1_ready),
    .axiov(axiov), .axiod(axiod), .grant(grant), .busy(busy),
    .frame_done(frame_done), .underrun(underrun)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic clear();
    for (int s = 0; s < 2; s++) begin
      nf[s] = 0;
      fi[s] = 0;
      ptr[s] = 0;
    end
  endtask

  task automatic add(input int s, input int n, input int drop);
    fn[s][nf[s]] = n;
    fdrop[s][nf[s]] = drop;
    for (int j = 0; j < n; j++) fb[s][nf[s]][j] = 8'($urandom);
    nf[s]++;
  endtask

  task automatic drive();
    logic v[2], l[2];
    logic [7:0] d[2];
    for (int s = 0; s < 2; s++) begin
      v[s] = 1'b0;
      l[s] = 1'b0;
      d[s] = 8'd0;
      if (fi[s] < nf[s]) begin
        v[s] = ptr[s] != fdrop[s][fi[s]];
        d[s] = fb[s][fi[s]][ptr[s]];
        l[s] = ptr[s] == fn[s][fi[s]] - 1;
      end
    end
    s0_valid = v[0]; s0_data = d[0]; s0_last = l[0];
    s1_valid = v[1]; s1_data = d[1]; s1_last = l[1];
  endtask

  // Expected timeline: frames granted in round-robin order, each = preamble+SFD, bytes, optional pad, IFG, one idle cycle.
  task automatic build();
    int t, rem[2], cur[2], s, n, d, m, nb, len;
    logic [7:0] b;
    for (int i = 0; i < H; i++) begin
      ev[i] = 0; eb[i] = 0; efd[i] = 0; eu[i] = 0; er0[i] = 0; er1[i] = 0; ed[i] = 0; eg[i] = 0;
    end
    t = 0;
    rem[0] = nf[0]; rem[1] = nf[1]; cur[0] = 0; cur[1] = 0;
    while (rem[0] + rem[1] > 0) begin
      s = (rem[0] > 0 && rem[1] > 0) ? mpri : (rem[1] > 0 ? 1 : 0);
      mpri = 1 - s;
      n = fn[s][cur[s]];
      d = fdrop[s][cur[s]];
      m = d < 0 ? n : d;
      nb = m;
`ifdef ETH_TX_SCHED_PAD_EN
      if (d < 0 && nb < 60) nb = 60;
`endif
      len = 32 + 4 * nb;
      for (int i = 0; i < len + 48; i++) begin
        eb[t + i] = 1'b1;
        if (i < len) begin
          ev[t + i] = 1'b1;
          eg[t + i] = s ? 2'b10 : 2'b01;
        end
      end
      for (int i = 0; i < 32; i++) ed[t + i] = i == 31 ? 2'b11 : 2'b01;
      for (int j = 0; j < nb; j++) begin
        b = j < m ? fb[s][cur[s]][j] : 8'h00;
        for (int k = 0; k < 4; k++) ed[t + 32 + 4 * j + k] = b[2 * k +: 2];
      end
      for (int k = 0; k <= (d < 0 ? n - 1 : d); k++)
        if (s == 1) er1[t + 31 + 4 * k] = 1'b1;
        else er0[t + 31 + 4 * k] = 1'b1;
      if (d < 0) efd[t + len] = 1'b1;
      else eu[t + len] = 1'b1;
      t += len + 49;
      cur[s]++;
      rem[s]--;
    end
    horizon = t;
  endtask

  task automatic run(input int stop);
    logic acc[2], ab[2];
    build();
    @(posedge clk); #1;
    drive();
    @(posedge clk);
    for (int i = 0; i < horizon && i < stop; i++) begin
      @(negedge clk);
      chk($sformatf("axiov@%0d", i), 8'(axiov), 8'(ev[i]));
      if (ev[i]) chk($sformatf("axiod@%0d", i), 8'(axiod), 8'(ed[i]));
      chk($sformatf("grant@%0d", i), 8'(grant), 8'(eg[i]));
      chk($sformatf("busy@%0d", i), 8'(busy), 8'(eb[i]));
      chk($sformatf("s0_ready@%0d", i), 8'(s0_ready), 8'(er0[i]));
      chk($sformatf("s1_ready@%0d", i), 8'(s1_ready), 8'(er1[i]));
      chk($sformatf("frame_done@%0d", i), 8'(frame_done), 8'(efd[i]));
      chk($sformatf("underrun@%0d", i), 8'(underrun), 8'(eu[i]));
      acc[0] = s0_ready && s0_valid; ab[0] = s0_ready && !s0_valid;
      acc[1] = s1_ready && s1_valid; ab[1] = s1_ready && !s1_valid;
      @(posedge clk); #1;
      for (int s = 0; s < 2; s++) begin
        if (acc[s]) begin
          ptr[s]++;
          if (ptr[s] == fn[s][fi[s]]) begin
            fi[s]++;
            ptr[s] = 0;
          end
        end
        if (ab[s]) begin
          fi[s]++;
          ptr[s] = 0;
        end
      end
      drive();
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #11;
    chk("rst_axiov", 8'(axiov), 8'd0);
    chk("rst_axiod", 8'(axiod), 8'd0);
    chk("rst_grant", 8'(grant), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_s0_ready", 8'(s0_ready), 8'd0);
    chk("rst_s1_ready", 8'(s1_ready), 8'd0);
    chk("rst_frame_done", 8'(frame_done), 8'd0);
    chk("rst_underrun", 8'(underrun), 8'd0);
    @(negedge clk) rst_n = 1'b1;
    // both sources request together at reset exit: source 0 first, then source 1
    clear(); add(0, 2, -1); add(1, 2, -1); run(H);
    // fixed A5,0F,FF frame from source 0
    clear(); add(0, 3, -1);
    fb[0][0][0] = 8'hA5; fb[0][0][1] = 8'h0F; fb[0][0][2] = 8'hFF;
    run(H);
    // source 1 drops valid on its second ready pulse
    clear(); add(1, 3, 1); run(H);
    // single-byte frame, padded when padding is built in
    clear(); add(0, 1, -1); fb[0][0][0] = 8'h11; run(H);
    // back-to-back frames from source 0 with source 1 also requesting
    clear(); add(0, 2, -1); add(0, 1, -1); add(1, 1, -1); run(H);
    for (int r = 0; r < 6; r++) begin
      clear();
      for (int s = 0; s < 2; s++)
        for (int f = 0; f < int'($urandom_range(0, 2)); f++) begin
          int n = int'($urandom_range(1, 12));
          add(s, n, $urandom_range(0, 3) == 0 ? int'($urandom_range(0, n - 1)) : -1);
        end
      if (nf[0] + nf[1] == 0) add(0, int'($urandom_range(1, 12)), -1);
      run(H);
    end
    // async reset mid-DATA, then a clean restart with source 0 priority
    clear(); add(0, 10, -1); run(40);
    rst_n = 1'b0;
    #1;
    chk("midrst_axiov", 8'(axiov), 8'd0);
    chk("midrst_grant", 8'(grant), 8'd0);
    chk("midrst_busy", 8'(busy), 8'd0);
    clear(); drive();
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    mpri = 0;
    clear(); add(1, 2, -1); add(0, 2, -1); run(H);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
